// File: rtl/reversible_pipe_adder.sv
// reversible_pipe_adder
// Pipelined add/subtract unit for the MAC datapath. A WIDTH-bit operation is
// split into NSTG = WIDTH/CHUNK ripple chunks, one chunk per register stage.
// Every chunk is a ripple of reversible full-adder cells (two Peres gates per
// bit). Operand bits that have not been added yet travel with the beat and
// shrink by CHUNK bits per stage. Finished result bits grow by CHUNK bits per
// stage. The output is valid NSTG cycles after acceptance, with full
// valid/ready back-pressure.
//
// Ports:
//   clk        clock, rising edge
//   rst        synchronous active-high reset, clears all stages
//   in_valid   operand beat valid
//   in_ready   block accepts a beat this cycle (= !stall)
//   a, b       WIDTH-bit operands
//   cin        carry-in (add) / borrow-in (subtract)
//   sub        0: a+b+cin, 1: a-b-cin
//   out_valid  result beat valid
//   out_ready  downstream accepts the result beat
//   sum        WIDTH-bit result, modulo 2^WIDTH
//   cout       add: carry-out; subtract: 1 means no borrow
//   overflow   two's-complement signed overflow

module reversible_pipe_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int CHUNK_SAFE = (CHUNK < 1) ? 1 : CHUNK;
  localparam int NSTG       = WIDTH / CHUNK_SAFE;

  if ((CHUNK < 1) || ((WIDTH % CHUNK_SAFE) != 0)) begin : g_badParams
    $error("reversible_pipe_adder: WIDTH must be a positive multiple of CHUNK");
  end

  // Reversible full adder: Peres(x, y, 0) gives x^y and x&y.
  // Peres(x^y, c, x&y) then gives the sum and the carry-out.
  function automatic logic [1:0] revFullAdd(input logic x, input logic y, input logic c);
    logic p1q, p1r;
    p1q = x ^ y;
    p1r = x & y;
    return {(p1q & c) ^ p1r, p1q ^ c};
  endfunction

  // One ripple chunk. It returns {carry-out, CHUNK sum bits}.
  function automatic logic [CHUNK_SAFE:0] addChunk(input logic [CHUNK_SAFE-1:0] x,
                                                   input logic [CHUNK_SAFE-1:0] y,
                                                   input logic c);
    logic [CHUNK_SAFE-1:0] s;
    logic [1:0]            fa;
    logic                  cy;
    s  = '0;
    cy = c;
    for (int i = 0; i < CHUNK_SAFE; i++) begin
      fa   = revFullAdd(x[i], y[i], cy);
      s[i] = fa[0];
      cy   = fa[1];
    end
    return {cy, s};
  endfunction

  logic             w_stall;
  logic             w_adv;
  logic [WIDTH-1:0] w_bEff;
  logic             w_cEff;

  // Subtract is implemented as a + ~b + ~cin.
  // The borrow-in becomes an inverted carry-in.
  assign w_bEff = sub ? ~b : b;
  assign w_cEff = sub ? ~cin : cin;

  // A stall freezes the whole pipe. Bubbles are not compacted.
  assign w_stall  = out_valid && !out_ready;
  assign w_adv    = !w_stall;
  assign in_ready = !w_stall;

  for (genvar k = 0; k < NSTG; k++) begin : g_stg
    localparam int REM = WIDTH - k * CHUNK_SAFE;

    logic                         w_vIn;
    logic                         w_cIn;
    logic [REM-1:0]               w_aRem;
    logic [REM-1:0]               w_bRem;
    logic [CHUNK_SAFE:0]          w_res;
    logic [(k+1)*CHUNK_SAFE-1:0]  w_sNext;
    logic                         r_valid;
    logic                         r_c;
    logic [(k+1)*CHUNK_SAFE-1:0]  r_s;

    if (k == 0) begin : g_src
      assign w_vIn   = in_valid;
      assign w_cIn   = w_cEff;
      assign w_aRem  = a;
      assign w_bRem  = w_bEff;
      assign w_sNext = w_res[CHUNK_SAFE-1:0];
    end else begin : g_src
      assign w_vIn   = g_stg[k-1].r_valid;
      assign w_cIn   = g_stg[k-1].r_c;
      assign w_aRem  = g_stg[k-1].g_fwd.r_a;
      assign w_bRem  = g_stg[k-1].g_fwd.r_b;
      assign w_sNext = {w_res[CHUNK_SAFE-1:0], g_stg[k-1].r_s};
    end

    // The lowest remaining operand bits are the chunk this stage adds.
    assign w_res = addChunk(w_aRem[CHUNK_SAFE-1:0], w_bRem[CHUNK_SAFE-1:0], w_cIn);

    always_ff @(posedge clk) begin
      if (rst) begin
        r_valid <= 1'b0;
        r_c     <= 1'b0;
        r_s     <= '0;
      end else if (w_adv) begin
        r_valid <= w_vIn;
        r_c     <= w_res[CHUNK_SAFE];
        r_s     <= w_sNext;
      end
    end

    if (k < NSTG - 1) begin : g_fwd
      logic [REM-CHUNK_SAFE-1:0] r_a;
      logic [REM-CHUNK_SAFE-1:0] r_b;

      always_ff @(posedge clk) begin
        if (rst) begin
          r_a <= '0;
          r_b <= '0;
        end else if (w_adv) begin
          r_a <= w_aRem[REM-1:CHUNK_SAFE];
          r_b <= w_bRem[REM-1:CHUNK_SAFE];
        end
      end
    end else begin : g_flag
      logic r_ov;

      // The carry into the MSB is recovered from the MSB sum bit
      // (s = a ^ b ^ carry-in). Overflow is that carry XOR the carry-out.
      always_ff @(posedge clk) begin
        if (rst) begin
          r_ov <= 1'b0;
        end else if (w_adv) begin
          r_ov <= (w_res[CHUNK_SAFE-1] ^ w_aRem[CHUNK_SAFE-1] ^ w_bRem[CHUNK_SAFE-1])
                  ^ w_res[CHUNK_SAFE];
        end
      end
    end
  end

  assign out_valid = g_stg[NSTG-1].r_valid;
  assign sum       = g_stg[NSTG-1].r_s;
  assign cout      = g_stg[NSTG-1].r_c;
  assign overflow  = g_stg[NSTG-1].g_flag.r_ov;

endmodule

// File: tb/tb_reversible_pipe_adder.sv
// tb_reversible_pipe_adder
// Directed table of hand-computed vectors. Hand-written back-pressure and
// mid-stream reset sequences. A randomized mixed add/subtract stream checked
// against an arithmetic reference model.

module tb_reversible_pipe_adder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic        sub;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] sum;
  logic        cout;
  logic        overflow;

  reversible_pipe_adder #(.WIDTH(16), .CHUNK(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic [15:0] expSum;
    logic        expCout;
    logic        expOv;
  } vec_t;

  typedef struct {
    logic [15:0] s;
    logic        c;
    logic        o;
    int          nAcc;
  } exp_t;

  vec_t vecs [10];
  exp_t sbQ [$];
  int   nVec = 0;
  int   nMis = 0;
  int   nonStall = 0;

  // Arithmetic reference: a 17-bit add or subtract, with flags from the operand signs.
  function automatic exp_t refModel(input logic [15:0] ra, input logic [15:0] rb,
                                    input logic rc, input logic rs);
    logic [16:0] full;
    exp_t        e;
    if (!rs) begin
      full = {1'b0, ra} + {1'b0, rb} + {16'b0, rc};
      e.s  = full[15:0];
      e.c  = full[16];
      e.o  = (ra[15] == rb[15]) && (e.s[15] != ra[15]);
    end else begin
      full = {1'b0, ra} - {1'b0, rb} - {16'b0, rc};
      e.s  = full[15:0];
      e.c  = ~full[16];
      e.o  = (ra[15] != rb[15]) && (e.s[15] != ra[15]);
    end
    e.nAcc = 0;
    return e;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    nVec++;
    if (act !== req) begin
      nMis++;
      $display("[TB] FAIL %s: got %0h, required %0h at %0t", name, act, req, $time);
    end
  endtask

  // One clock cycle, entered and left at a falling edge.
  // Whenever out_valid is high, the output must match the scoreboard head, so
  // a stalled output must also hold steady. Retired beats must have seen
  // exactly four non-stalled cycles since acceptance.
  task automatic stepCycle(input logic iv, input logic [15:0] ia, input logic [15:0] ib,
                           input logic icin, input logic isub, input logic ordy,
                           input exp_t e, output logic acc, output logic ret,
                           output logic ir);
    in_valid  = iv;
    a         = ia;
    b         = ib;
    cin       = icin;
    sub       = isub;
    out_ready = ordy;
    #1;
    ir  = in_ready;
    acc = iv && in_ready;
    ret = 1'b0;
    checkOutput("inReady", {31'b0, in_ready}, {31'b0, !(out_valid && !ordy)});
    if (!(out_valid && !ordy)) nonStall++;
    if (out_valid) begin
      if (sbQ.size() == 0) begin
        checkOutput("spuriousValid", {31'b0, out_valid}, 32'd0);
      end else begin
        checkOutput("sum", {16'b0, sum}, {16'b0, sbQ[0].s});
        checkOutput("cout", {31'b0, cout}, {31'b0, sbQ[0].c});
        checkOutput("overflow", {31'b0, overflow}, {31'b0, sbQ[0].o});
        if (ordy) begin
          ret = 1'b1;
          checkOutput("latency", nonStall - sbQ[0].nAcc, 32'd4);
          void'(sbQ.pop_front());
        end
      end
    end
    if (acc) begin
      e.nAcc = nonStall;
      sbQ.push_back(e);
    end
    @(negedge clk);
  endtask

  task automatic applyStimulus(input vec_t v);
    exp_t e;
    logic acc, ret, ir;
    e.s = v.expSum; e.c = v.expCout; e.o = v.expOv; e.nAcc = 0;
    stepCycle(1'b1, v.a, v.b, v.cin, v.sub, 1'b1, e, acc, ret, ir);
    checkOutput("accept", {31'b0, acc}, 32'd1);
    for (int i = 0; i < 12 && sbQ.size() != 0; i++)
      stepCycle(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1, e, acc, ret, ir);
    checkOutput("drainTimeout", sbQ.size(), 32'd0);
    sbQ.delete();
  endtask

  task automatic checkResetState();
    checkOutput("rstOutValid", {31'b0, out_valid}, 32'd0);
    checkOutput("rstSum", {16'b0, sum}, 32'd0);
    checkOutput("rstCout", {31'b0, cout}, 32'd0);
    checkOutput("rstOverflow", {31'b0, overflow}, 32'd0);
    checkOutput("rstInReady", {31'b0, in_ready}, 32'd1);
  endtask

  initial begin
    exp_t        e;
    logic        acc, ret, ir, ordy, pend, pc, ps;
    logic [15:0] pa, pb;
    int          sent, got, holdLeft;
    logic        holdDone, released;

    vecs[0] = '{16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0, 1'b0};
    vecs[1] = '{16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[3] = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    vecs[4] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    vecs[5] = '{16'h0010, 16'h0003, 1'b1, 1'b1, 16'h000C, 1'b1, 1'b0};
    vecs[6] = '{16'h8000, 16'h8000, 1'b1, 1'b0, 16'h0001, 1'b1, 1'b1};
    vecs[7] = '{16'hABCD, 16'h1234, 1'b0, 1'b0, 16'hBE01, 1'b0, 1'b0};
    vecs[8] = '{16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};
    vecs[9] = '{16'h7FFF, 16'hFFFF, 1'b0, 1'b1, 16'h8000, 1'b0, 1'b1};

    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
    e = refModel(16'h0, 16'h0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    checkResetState();
    rst = 1'b0;

    // Directed table
    for (int i = 0; i < 10; i++) applyStimulus(vecs[i]);

    // Back-pressure: 8 beats, with out_ready held low for 5 cycles once the first result shows
    sent = 0; got = 0; holdLeft = 0; holdDone = 1'b0; released = 1'b0;
    for (int cyc = 0; cyc < 80 && got < 8; cyc++) begin
      if (!holdDone && holdLeft == 0 && out_valid) begin
        holdLeft = 5;
        holdDone = 1'b1;
      end
      ordy = (holdLeft == 0);
      e = refModel(16'(sent), 16'(sent << 4), 1'b0, 1'b0);
      stepCycle(sent < 8, 16'(sent), 16'(sent << 4), 1'b0, 1'b0, ordy, e, acc, ret, ir);
      if (holdLeft > 0) begin
        checkOutput("holdInReady", {31'b0, ir}, 32'd0);
        holdLeft--;
        if (holdLeft == 0) released = 1'b1;
      end else if (released) begin
        checkOutput("throughput", {31'b0, ret}, 32'd1);
      end
      if (acc) sent++;
      if (ret) got++;
    end
    checkOutput("bpHoldSeen", {31'b0, holdDone}, 32'd1);
    checkOutput("bpCount", got, 32'd8);
    sbQ.delete();

    // Random bubbles, mixed modes, random out_ready
    sent = 0; pend = 1'b0; pa = '0; pb = '0; pc = 1'b0; ps = 1'b0;
    for (int cyc = 0; cyc < 20000 && (sent < 1000 || sbQ.size() != 0); cyc++) begin
      if (!pend && sent < 1000 && $urandom_range(0, 1) == 1) begin
        pa   = 16'($urandom);
        pb   = 16'($urandom);
        pc   = 1'($urandom_range(0, 1));
        ps   = 1'($urandom_range(0, 1));
        pend = 1'b1;
      end
      ordy = ($urandom_range(0, 3) != 0);
      e = refModel(pa, pb, pc, ps);
      stepCycle(pend, pa, pb, pc, ps, ordy, e, acc, ret, ir);
      if (acc) begin
        sent++;
        pend = 1'b0;
      end
    end
    checkOutput("randSent", sent, 32'd1000);
    checkOutput("randDrain", sbQ.size(), 32'd0);
    sbQ.delete();

    // Mid-stream reset: in-flight beats must vanish
    for (int i = 0; i < 3; i++) begin
      e = refModel(16'(i + 100), 16'h0F0F, 1'b1, 1'b0);
      stepCycle(1'b1, 16'(i + 100), 16'h0F0F, 1'b1, 1'b0, 1'b1, e, acc, ret, ir);
    end
    rst = 1'b1;
    in_valid = 1'b1;
    repeat (2) @(negedge clk);
    checkResetState();
    rst = 1'b0;
    sbQ.delete();
    for (int i = 0; i < 10; i++)
      stepCycle(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1, e, acc, ret, ir);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end

endmodule
